// File: rtl/irf_pkg.sv
// Shared types, encodings and helpers for the integer register file / operand stage.
// Optional feature macro used by this slice: IRF_BYPASS_EN (writeback-to-read forwarding).
package irf_pkg;

    // Default datapath width.
    localparam int unsigned XLEN_DEFAULT = 64;

    // Widest datapath the sign-extend helper supports.
    localparam int unsigned MAX_XLEN = 128;

    // Operand 1 (mux1) select encodings.
    localparam logic [1:0] SRC1_REG  = 2'd0;
    localparam logic [1:0] SRC1_DISP = 2'd1;
    localparam logic [1:0] SRC1_PC   = 2'd2;
    localparam logic [1:0] SRC1_ZERO = 2'd3;

    // Operand 2 (mux2) select encodings.
    localparam logic SRC2_REG = 1'b0;
    localparam logic SRC2_LIT = 1'b1;

    // Sign-extend the low 'width' bits of 'value' to MAX_XLEN bits; callers truncate to XLEN.
    function automatic logic [MAX_XLEN-1:0] sign_extend(input logic [MAX_XLEN-1:0] value,
                                                        input int unsigned width);
        logic [MAX_XLEN-1:0] shifted;
        shifted = value << (MAX_XLEN - width);
        return $unsigned($signed(shifted) >>> (MAX_XLEN - width));
    endfunction

endpackage

// File: rtl/irf_operand_stage_if.sv
// Decode-side, writeback and execute-side signals of the operand stage, bundled.
// 'master' is the environment (decode / writeback / execute), 'slave' is the stage.
interface irf_operand_stage_if
    import irf_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter int unsigned AW   = 5
) ();

    // Decode side
    logic            in_valid;
    logic            in_ready;
    logic [AW-1:0]   rd_addr_a;
    logic [AW-1:0]   rd_addr_b;
    logic            dest_en;
    logic [AW-1:0]   dest_addr;
    logic [15:0]     displacement;
    logic [7:0]      literal;
    logic [XLEN-1:0] pc;
    logic [1:0]      mux1_sel;
    logic            mux2_sel;

    // Writeback side
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;

    // Execute side
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out1;
    logic [XLEN-1:0] out2;
    logic [XLEN-1:0] reg_a_dly;
    logic [XLEN-1:0] reg_b_dly;

    modport master (
        output in_valid, rd_addr_a, rd_addr_b, dest_en, dest_addr, displacement, literal, pc,
        output mux1_sel, mux2_sel, wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, out1, out2, reg_a_dly, reg_b_dly
    );

    modport slave (
        input  in_valid, rd_addr_a, rd_addr_b, dest_en, dest_addr, displacement, literal, pc,
        input  mux1_sel, mux2_sel, wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, out1, out2, reg_a_dly, reg_b_dly
    );

endinterface

// File: rtl/irf_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register, set on issue, cleared on writeback.
// With IRF_BYPASS_EN defined, a same-cycle writeback hides the busy bit from the source queries.
module irf_scoreboard
    import irf_pkg::*;
#(
    parameter int unsigned NREGS    = 32,
    parameter int unsigned ZERO_REG = NREGS - 1,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset_n,
    // Set port: accepted instruction with a destination
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    // Clear port: writeback
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    // Source A / source B / destination (WAW) queries
    input  logic [AW-1:0] qa_addr,
    input  logic [AW-1:0] qb_addr,
    input  logic [AW-1:0] qw_addr,
    output logic          qa_busy,
    output logic          qb_busy,
    output logic          qw_busy
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Next busy state: apply the writeback clear first so a same-register set overrides it.
    always_comb begin
        busy_d = busy_q;
        if (clr_en && (clr_addr != ZERO_ADDR)) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en && (set_addr != ZERO_ADDR)) begin
            busy_d[set_addr] = 1'b1;
        end
    end

    // Busy-bit register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Hazard queries; the zero register is masked explicitly so it can never look busy.
    always_comb begin
        qa_busy = busy_q[qa_addr] && (qa_addr != ZERO_ADDR);
        qb_busy = busy_q[qb_addr] && (qb_addr != ZERO_ADDR);
        qw_busy = busy_q[qw_addr] && (qw_addr != ZERO_ADDR);
`ifdef IRF_BYPASS_EN
        // The value being written this cycle is forwarded, so the source is effectively ready.
        if (clr_en && (clr_addr == qa_addr)) begin
            qa_busy = 1'b0;
        end
        if (clr_en && (clr_addr == qb_addr)) begin
            qb_busy = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/irf_operand_stage.sv
// Integer register file and operand-select stage between decode and execute.
// Holds the register file with a hardwired zero register, a busy-bit scoreboard that stalls
// dependent instructions, a valid/ready output register for the two selected operands and
// delay lines carrying the raw register reads to later stages.
// Optional feature: define IRF_BYPASS_EN to forward same-cycle writeback data to the read ports.
module irf_operand_stage
    import irf_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEFAULT,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned ZERO_REG = NREGS - 1,
    parameter int unsigned DLY_A    = 2,
    parameter int unsigned DLY_B    = 3
) (
    input logic                clk,
    input logic                reset_n,
    irf_operand_stage_if.slave bus
);

    localparam int unsigned   AW        = $clog2(NREGS);
    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] rdata_a;
    logic [XLEN-1:0] rdata_b;
    logic [XLEN-1:0] disp_ext;
    logic [XLEN-1:0] lit_ext;
    logic [XLEN-1:0] mux1_res;
    logic [XLEN-1:0] mux2_res;

    logic            wb_write;
    logic            busy_a;
    logic            busy_b;
    logic            busy_w;
    logic            hazard;
    logic            in_ready;
    logic            accept;

    logic            out_valid_q;
    logic [XLEN-1:0] out1_q;
    logic [XLEN-1:0] out2_q;

    logic [XLEN-1:0] dly_a_q [DLY_A];
    logic [XLEN-1:0] dly_b_q [DLY_B];

    // Writes to the zero register are dropped here and in the scoreboard.
    assign wb_write = bus.wb_en && (bus.wb_addr != ZERO_ADDR);

    // Register file write port; writeback is never stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_write) begin
            regs_q[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Combinational read ports, zero register forced to 0, optional writeback forwarding.
    always_comb begin
        rdata_a = (bus.rd_addr_a == ZERO_ADDR) ? '0 : regs_q[bus.rd_addr_a];
        rdata_b = (bus.rd_addr_b == ZERO_ADDR) ? '0 : regs_q[bus.rd_addr_b];
`ifdef IRF_BYPASS_EN
        if (wb_write && (bus.wb_addr == bus.rd_addr_a)) begin
            rdata_a = bus.wb_data;
        end
        if (wb_write && (bus.wb_addr == bus.rd_addr_b)) begin
            rdata_b = bus.wb_data;
        end
`endif
    end

    assign disp_ext = XLEN'(sign_extend(MAX_XLEN'(bus.displacement), 16));
    assign lit_ext  = XLEN'(sign_extend(MAX_XLEN'(bus.literal), 8));

    // Operand muxes.
    always_comb begin
        mux1_res = '0;
        case (bus.mux1_sel)
            SRC1_REG:  mux1_res = rdata_a;
            SRC1_DISP: mux1_res = disp_ext;
            SRC1_PC:   mux1_res = bus.pc;
            SRC1_ZERO: mux1_res = '0;
            default:   mux1_res = '0;
        endcase
        mux2_res = (bus.mux2_sel == SRC2_LIT) ? lit_ext : rdata_b;
    end

    irf_scoreboard #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .reset_n  (reset_n),
        .set_en   (accept && bus.dest_en),
        .set_addr (bus.dest_addr),
        .clr_en   (bus.wb_en),
        .clr_addr (bus.wb_addr),
        .qa_addr  (bus.rd_addr_a),
        .qb_addr  (bus.rd_addr_b),
        .qw_addr  (bus.dest_addr),
        .qa_busy  (busy_a),
        .qb_busy  (busy_b),
        .qw_busy  (busy_w)
    );

    // Stall on RAW for any source actually selected, or on WAW for the destination.
    always_comb begin
        hazard   = ((bus.mux1_sel == SRC1_REG) && busy_a) ||
                   ((bus.mux2_sel == SRC2_REG) && busy_b) ||
                   (bus.dest_en && busy_w);
        in_ready = (!out_valid_q || bus.out_ready) && !hazard;
        accept   = bus.in_valid && in_ready;
    end

    // Output register: load on accept, drop valid once consumed, hold under back-pressure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out1_q      <= '0;
            out2_q      <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out1_q      <= mux1_res;
            out2_q      <= mux2_res;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Raw operand A delay line, advancing only on accepted transfers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DLY_A; i++) begin
                dly_a_q[i] <= '0;
            end
        end else if (accept) begin
            dly_a_q[0] <= rdata_a;
            for (int unsigned i = 1; i < DLY_A; i++) begin
                dly_a_q[i] <= dly_a_q[i-1];
            end
        end
    end

    // Raw operand B delay line, advancing only on accepted transfers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DLY_B; i++) begin
                dly_b_q[i] <= '0;
            end
        end else if (accept) begin
            dly_b_q[0] <= rdata_b;
            for (int unsigned i = 1; i < DLY_B; i++) begin
                dly_b_q[i] <= dly_b_q[i-1];
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out1      = out1_q;
    assign bus.out2      = out2_q;
    assign bus.reg_a_dly = dly_a_q[DLY_A-1];
    assign bus.reg_b_dly = dly_b_q[DLY_B-1];

endmodule

// File: tb/tb_irf_operand_stage.sv
// Directed bench for irf_operand_stage; expected operand pairs are queued when an accept is
// expected and compared when the stage hands a pair to execute.
module tb_irf_operand_stage;
    import irf_pkg::*;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DLY_A = 2;
    localparam int unsigned DLY_B = 3;

    typedef struct packed {
        logic [63:0] o1;
        logic [63:0] o2;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    irf_operand_stage_if #(.XLEN(XLEN), .AW(AW)) bus ();

    irf_operand_stage #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .ZERO_REG (NREGS - 1),
        .DLY_A    (DLY_A),
        .DLY_B    (DLY_B)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.wb_en    = 1'b0;
        bus.dest_en  = 1'b0;
    endtask

    task automatic issue(input logic [4:0] a, input logic [4:0] b, input logic [1:0] m1,
                         input logic m2, input logic den, input logic [4:0] dst,
                         input logic [15:0] disp, input logic [7:0] lit, input logic [63:0] pcv);
        bus.in_valid     = 1'b1;
        bus.rd_addr_a    = a;
        bus.rd_addr_b    = b;
        bus.mux1_sel     = m1;
        bus.mux2_sel     = m2;
        bus.dest_en      = den;
        bus.dest_addr    = dst;
        bus.displacement = disp;
        bus.literal      = lit;
        bus.pc           = pcv;
    endtask

    task automatic wb(input logic [4:0] addr, input logic [63:0] data);
        bus.wb_en   = 1'b1;
        bus.wb_addr = addr;
        bus.wb_data = data;
    endtask

    task automatic push(input logic [63:0] o1, input logic [63:0] o2);
        exp_q.push_back({o1, o2});
    endtask

    // Scoreboard side: every transfer to execute must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_transfer: observed out1 %h out2 %h, expected none",
                       bus.out1, bus.out2);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out1", bus.out1, e.o1);
                check("out2", bus.out2, e.o2);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] a_seq [4];
        logic [4:0] b_seq [4];
        a_seq = '{5'd1, 5'd2, 5'd3, 5'd4};
        b_seq = '{5'd4, 5'd2, 5'd1, 5'd3};

        bus.out_ready = 1'b1;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
        issue(5'd0, 5'd0, SRC1_REG, SRC2_REG, 1'b0, 5'd0, 16'h0, 8'h0, 64'h0);
        idle();
        reset_n = 1'b0;
        repeat (2) cyc();

        // Reset state
        check("rst_out_valid", bus.out_valid, 64'd0);
        check("rst_out1", bus.out1, 64'd0);
        check("rst_out2", bus.out2, 64'd0);
        check("rst_reg_a_dly", bus.reg_a_dly, 64'd0);
        check("rst_reg_b_dly", bus.reg_b_dly, 64'd0);
        check("rst_in_ready", bus.in_ready, 64'd1);
        reset_n = 1'b1;
        cyc();

        // Register read and zero register
        wb(5'd3, 64'h1234);
        cyc();
        wb(5'd31, 64'hDEAD);
        cyc();
        idle();
        issue(5'd3, 5'd31, SRC1_REG, SRC2_REG, 1'b0, 5'd0, 16'h0, 8'h0, 64'h0);
        #1 check("rd_in_ready", bus.in_ready, 64'd1);
        push(64'h1234, 64'h0);
        cyc();

        // Sign extension, PC and zero selects, back to back
        issue(5'd0, 5'd0, SRC1_DISP, SRC2_LIT, 1'b0, 5'd0, 16'h8000, 8'hFF, 64'h0);
        #1 check("sext_in_ready", bus.in_ready, 64'd1);
        push(64'hFFFF_FFFF_FFFF_8000, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc();
        issue(5'd0, 5'd3, SRC1_PC, SRC2_REG, 1'b0, 5'd0, 16'h0, 8'h0, 64'h1000_0000_0000_0042);
        #1 check("pc_in_ready", bus.in_ready, 64'd1);
        push(64'h1000_0000_0000_0042, 64'h1234);
        cyc();
        issue(5'd0, 5'd0, SRC1_ZERO, SRC2_LIT, 1'b0, 5'd0, 16'h7FFF, 8'h7F, 64'h0);
        #1 check("zero_in_ready", bus.in_ready, 64'd1);
        push(64'h0, 64'h7F);
        cyc();
        idle();

        // Set and clear of the same busy bit in one cycle: set wins
        issue(5'd0, 5'd0, SRC1_ZERO, SRC2_LIT, 1'b1, 5'd13, 16'h0, 8'h0, 64'h0);
        wb(5'd13, 64'h13);
        #1 check("setclr_in_ready", bus.in_ready, 64'd1);
        push(64'h0, 64'h0);
        cyc();
        idle();
        issue(5'd13, 5'd0, SRC1_REG, SRC2_LIT, 1'b0, 5'd0, 16'h0, 8'h0, 64'h0);
        #1 check("set_wins_stall", bus.in_ready, 64'd0);
        idle();
        wb(5'd13, 64'h55);
        cyc();
        idle();

        // RAW stall on r7 until writeback
        issue(5'd0, 5'd0, SRC1_ZERO, SRC2_LIT, 1'b1, 5'd7, 16'h0, 8'h0, 64'h0);
        #1 check("raw_issue_ready", bus.in_ready, 64'd1);
        push(64'h0, 64'h0);
        cyc();
        idle();
        issue(5'd7, 5'd0, SRC1_REG, SRC2_LIT, 1'b0, 5'd0, 16'h0, 8'h01, 64'h0);
        #1 check("raw_stall0", bus.in_ready, 64'd0);
        cyc();
        check("raw_stall1", bus.in_ready, 64'd0);
        wb(5'd7, 64'hAB);
        #1;
`ifdef IRF_BYPASS_EN
        check("raw_wb_cycle_ready", bus.in_ready, 64'd1);
        push(64'hAB, 64'h1);
        cyc();
`else
        check("raw_wb_cycle_stall", bus.in_ready, 64'd0);
        cyc();
        bus.wb_en = 1'b0;
        #1 check("raw_after_wb_ready", bus.in_ready, 64'd1);
        push(64'hAB, 64'h1);
        cyc();
`endif
        idle();
        cyc();

        // Back-pressure: outputs hold, no accept, no extra busy set
        bus.out_ready = 1'b0;
        issue(5'd0, 5'd0, SRC1_DISP, SRC2_LIT, 1'b1, 5'd9, 16'h0010, 8'h20, 64'h0);
        #1 check("bp_first_ready", bus.in_ready, 64'd1);
        push(64'h10, 64'h20);
        cyc();
        issue(5'd0, 5'd0, SRC1_DISP, SRC2_LIT, 1'b1, 5'd10, 16'h0030, 8'h40, 64'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", bus.in_ready, 64'd0);
            check("bp_out_valid", bus.out_valid, 64'd1);
            check("bp_out1", bus.out1, 64'h10);
            check("bp_out2", bus.out2, 64'h20);
            cyc();
        end
        bus.out_ready = 1'b1;
        #1 check("bp_release_ready", bus.in_ready, 64'd1);
        push(64'h30, 64'h40);
        cyc();
        idle();
        cyc();

        // Release busy r9/r10 and load r1..r4 with their own index
        wb(5'd9, 64'h99);
        cyc();
        wb(5'd10, 64'h100);
        cyc();
        for (int i = 1; i <= 4; i++) begin
            wb(5'(i), 64'(i));
            cyc();
        end
        idle();

        // Delay lines: four accepts, then a stalled and an idle cycle must not shift them
        for (int i = 0; i < 4; i++) begin
            issue(a_seq[i], b_seq[i], SRC1_REG, SRC2_REG, 1'b0, 5'd0, 16'h0, 8'h0, 64'h0);
            #1 check("dly_in_ready", bus.in_ready, 64'd1);
            push(64'(a_seq[i]), 64'(b_seq[i]));
            cyc();
        end
        check("dly_a_after4", bus.reg_a_dly, 64'd3);
        check("dly_b_after4", bus.reg_b_dly, 64'd2);
        bus.out_ready = 1'b0;
        issue(5'd1, 5'd1, SRC1_REG, SRC2_REG, 1'b0, 5'd0, 16'h0, 8'h0, 64'h0);
        #1 check("dly_stall_ready", bus.in_ready, 64'd0);
        cyc();
        check("dly_a_stall", bus.reg_a_dly, 64'd3);
        check("dly_b_stall", bus.reg_b_dly, 64'd2);
        idle();
        bus.out_ready = 1'b1;
        cyc();
        check("dly_a_idle", bus.reg_a_dly, 64'd3);
        check("dly_b_idle", bus.reg_b_dly, 64'd2);

        // in_valid low: no accept and no busy bit set
        issue(5'd0, 5'd0, SRC1_ZERO, SRC2_LIT, 1'b1, 5'd12, 16'h0, 8'h0, 64'h0);
        bus.in_valid = 1'b0;
        #1 check("novalid_ready", bus.in_ready, 64'd1);
        cyc();
        issue(5'd12, 5'd0, SRC1_REG, SRC2_LIT, 1'b0, 5'd0, 16'h0, 8'h0, 64'h0);
        #1 check("novalid_no_busy", bus.in_ready, 64'd1);
        push(64'h0, 64'h0);
        cyc();
        idle();
        cyc();

        // Reset mid-stream with a held output and busy r5
        bus.out_ready = 1'b0;
        issue(5'd0, 5'd0, SRC1_DISP, SRC2_LIT, 1'b1, 5'd5, 16'h0005, 8'h06, 64'h0);
        #1 check("midrst_issue_ready", bus.in_ready, 64'd1);
        cyc();
        idle();
        check("midrst_pre_valid", bus.out_valid, 64'd1);
        check("midrst_pre_out1", bus.out1, 64'h5);
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 64'd0);
        check("midrst_out1", bus.out1, 64'd0);
        check("midrst_out2", bus.out2, 64'd0);
        check("midrst_reg_a_dly", bus.reg_a_dly, 64'd0);
        check("midrst_reg_b_dly", bus.reg_b_dly, 64'd0);
        cyc();
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        issue(5'd3, 5'd0, SRC1_REG, SRC2_LIT, 1'b1, 5'd5, 16'h0, 8'h05, 64'h0);
        #1 check("midrst_ready_after", bus.in_ready, 64'd1);
        push(64'h0, 64'h5);
        cyc();
        idle();
        repeat (2) cyc();

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
